// File: rtl/frame_capture_pkg.sv
// Shared video-stream definitions for the capture tail of the processing pipeline:
// pixel width, default frame geometry and the capture FSM state encoding.
package frame_capture_pkg;

    localparam int PIXEL_W        = 8;
    localparam int DEFAULT_WIDTH  = 64;
    localparam int DEFAULT_HEIGHT = 48;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LINE,
        GAP,
        DONE
    } captureState_e;

endpackage

// File: rtl/frame_capture_if.sv
// Pixel stream as seen between two processing stages: data plus frame/line start strobes.
interface frame_capture_if;
    import frame_capture_pkg::*;

    logic [PIXEL_W-1:0] PixelIn;
    logic               FrameIn;
    logic               LineIn;

    modport master (output PixelIn, FrameIn, LineIn);
    modport slave  (input  PixelIn, FrameIn, LineIn);

endinterface

// File: rtl/frame_buffer_ram.sv
// Simple dual-port frame store: one write port, one registered read port (read-before-write).
module frame_buffer_ram #(
    parameter int DEPTH  = 3072,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [DATA_W-1:0] RdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
    always_ff @(posedge Clk) begin
        if (WrEn) mem[WrAddr] <= WrData;
    end

    // NOTE: non-blocking updates make a same-address read see the old word, not the one being written.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) RdData <= '0;
        else         RdData <= mem[RdAddr];
    end

endmodule

// File: rtl/frame_capture.sv
// Stream sink: once armed, captures the next complete frame into the buffer in raster order,
// flags short lines and mid-frame restarts, and serves registered readback at any time.
module frame_capture
    import frame_capture_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT,
    parameter int ADDR_W = 12
) (
    input  logic               Clk,
    input  logic               nReset,
    frame_capture_if.slave     Stream,
    input  logic               Arm,
    input  logic [ADDR_W-1:0]  RdAddr,
    output logic [PIXEL_W-1:0] RdData,
    output logic               Busy,
    output logic               FrameDone,
    output logic               ErrShort,
    output logic               ErrFrame
);

    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT + 1);
    localparam int DEPTH = WIDTH * HEIGHT;

    captureState_e     state, nextState;
    logic [XW-1:0]     xCnt, nextX;
    logic [YW-1:0]     yCnt, nextY, yInc;
    logic [ADDR_W-1:0] addr, nextAddr, wrAddr, lineStart;
    logic              wrEn, setShort, setFrame, clrErr;

    // addr always points at y*WIDTH+x, so the start of the next line is reachable without a multiply.
    assign yInc      = yCnt + YW'(1);
    assign lineStart = addr - ADDR_W'(xCnt) + ADDR_W'(WIDTH);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        nextState = state;
        nextX     = xCnt;
        nextY     = yCnt;
        nextAddr  = addr;
        wrEn      = 1'b0;
        wrAddr    = addr;
        setShort  = 1'b0;
        setFrame  = 1'b0;
        clrErr    = 1'b0;

        unique case (state)
            IDLE: begin
                if (Arm) begin
                    nextState = ARMED;
                    clrErr    = 1'b1;
                end
            end
            ARMED: begin
                if (Stream.FrameIn && Stream.LineIn) begin
                    wrEn      = 1'b1;
                    wrAddr    = '0;
                    nextAddr  = ADDR_W'(1);
                    nextX     = XW'(1);
                    nextY     = '0;
                    nextState = LINE;
                end else if (Stream.FrameIn) begin
                    setShort = 1'b1;
                end
            end
            LINE, GAP: begin
                if (Stream.FrameIn) begin
                    setFrame = 1'b1;
                    if (Stream.LineIn) begin
                        wrEn      = 1'b1;
                        wrAddr    = '0;
                        nextAddr  = ADDR_W'(1);
                        nextX     = XW'(1);
                        nextY     = '0;
                        nextState = LINE;
                    end else begin
                        nextState = ARMED;
                    end
                end else if (Stream.LineIn && state == GAP) begin
                    wrEn      = 1'b1;
                    nextAddr  = addr + ADDR_W'(1);
                    nextX     = XW'(1);
                    nextState = LINE;
                end else if (Stream.LineIn) begin
                    // Line cut short: this pixel opens the next line, unless the frame is already full.
                    setShort = 1'b1;
                    nextY    = yInc;
                    if (yInc == YW'(HEIGHT)) begin
                        nextState = DONE;
                    end else begin
                        wrEn      = 1'b1;
                        wrAddr    = lineStart;
                        nextAddr  = lineStart + ADDR_W'(1);
                        nextX     = XW'(1);
                        nextState = LINE;
                    end
                end else if (state == LINE) begin
                    wrEn     = 1'b1;
                    nextAddr = addr + ADDR_W'(1);
                    if (xCnt == XW'(WIDTH - 1)) begin
                        nextX     = '0;
                        nextY     = yInc;
                        nextState = (yCnt == YW'(HEIGHT - 1)) ? DONE : GAP;
                    end else begin
                        nextX = xCnt + XW'(1);
                    end
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            xCnt     <= '0;
            yCnt     <= '0;
            addr     <= '0;
            ErrShort <= 1'b0;
            ErrFrame <= 1'b0;
        end else begin
            state    <= nextState;
            xCnt     <= nextX;
            yCnt     <= nextY;
            addr     <= nextAddr;
            ErrShort <= clrErr ? 1'b0 : (ErrShort | setShort);
            ErrFrame <= clrErr ? 1'b0 : (ErrFrame | setFrame);
        end
    end

    assign Busy      = (state == ARMED) || (state == LINE) || (state == GAP);
    assign FrameDone = (state == DONE);

    frame_buffer_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (PIXEL_W)
    ) buffer (
        .Clk    (Clk),
        .nReset (nReset),
        .WrEn   (wrEn),
        .WrAddr (wrAddr),
        .WrData (Stream.PixelIn),
        .RdAddr (RdAddr),
        .RdData (RdData)
    );

endmodule
